pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 pipeline.
- Computes per-cycle stall and bubble controls for the F, D, E, M and W pipeline registers: load/use, ret and mispredicted-jump hazards, plus exception drain.
- Sequences the pipeline through start, run and halt with a small state machine.
- Optionally keeps performance counters. Sits beside the pipeline registers and drives their stall/bubble inputs.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- go  input  1  start pulse; leaves IDLE
- D_icode  input  4  icode in D register
- d_srcA  input  4  decode-stage srcA
- d_srcB  input  4  decode-stage srcB
- E_icode  input  4  icode in E register
- E_dstM  input  4  dstM in E register
- e_Cnd  input  1  execute-stage condition result
- M_icode  input  4  icode in M register
- m_stat  input  3  memory-stage status
- W_icode  input  4  icode in W register
- W_stat  input  3  status in W register
- F_stall  output  1  hold F (PC) register
- D_stall  output  1  hold D register
- D_bubble  output  1  load NOP into D
- E_bubble  output  1  load NOP into E
- M_bubble  output  1  load NOP into M
- W_stall  output  1  hold W register
- running  output  1  state == RUN
- halted  output  1  state == HALTED
- final_stat  output  3  W_stat latched on halt entry

Behaviour:
- Constants:
  - icodes: HALT=0, NOP=1, MRMOVQ=5, JXX=7, RET=9, POPQ=B.
  - RNONE=F.
  - stat: AOK=1, HLT=2, ADR=3, INS=4.
- Hazard terms, all combinational:
  - lu = (E_icode∈{MRMOVQ,POPQ}) & (E_dstM≠RNONE) & (E_dstM==d_srcA | E_dstM==d_srcB).
  - rt = RET∈{D_icode,E_icode,M_icode}.
  - mp = (E_icode==JXX) & ~e_Cnd.
  - exc(s) = s∈{HLT,ADR,INS}.
- RUN outputs:
  - F_stall = lu | rt
  - D_stall = lu
  - D_bubble = mp | (rt & ~lu)
  - E_bubble = mp | lu
  - M_bubble = exc(m_stat) | exc(W_stat)
  - W_stall = exc(W_stat)
- IDLE and HALTED outputs (frozen):
  - F_stall = D_stall = W_stall = 1
  - E_bubble = M_bubble = 1
  - D_bubble = 0
  - Stall has priority over bubble in D.
- States: IDLE (reset) → RUN on go=1.
  - RUN → HALTED on the clock edge where exc(W_stat)=1; final_stat <= W_stat on that edge.
  - HALTED is sticky until rst; go is ignored outside IDLE.
- Reset:
  - rst sampled on the clock edge: state=IDLE, final_stat=AOK, counters=0.
  - Outputs follow IDLE values in the cycle after the reset edge.
  - rst asserted mid-RUN aborts immediately; no drain.
- Simultaneous events:
  - go and rst together: rst wins.
  - lu & rt together: F/D stall, E bubble, D not bubbled.
  - mp & rt together: mp term dominates D_bubble (same value).
  - exc(W_stat) in RUN: outputs already show W_stall=1 in that cycle; the state change takes effect on the next edge.
- Latency: control outputs are combinational from inputs and state, with zero cycles of delay. State changes take effect one edge later.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- With the macro: add outputs cyc_cnt, ret_cnt, stall_cnt, bub_cnt, each CNT_W bits. All clear on rst and count only in RUN.
  - cyc_cnt +1 per RUN cycle.
  - ret_cnt +1 when W_stat==AOK & W_icode≠NOP.
  - stall_cnt +1 when F_stall.
  - bub_cnt +1 when D_bubble | E_bubble.
  - All counters saturate at all-ones; no wrap.
- Without the macro: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants
  - stat constants
  - RNONE
  - state encoding (IDLE=0, RUN=1, HALTED=2)
- Sub-module pipe_hazard_detect: purely combinational, computes lu/rt/mp from the stage inputs.
- pipe_ctrl holds the FSM, the freeze muxing and the counters.

Test Plan:
- Startup: rst=1 one cycle, go=0 five cycles → all frozen outputs at IDLE values, running=0. Pulse go → next cycle running=1 and outputs follow the hazard terms (all 0 with NOPs).
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. E_dstM=F with d_srcA=F → no stall.
- Ret: D_icode=9 held three cycles → F_stall=1 and D_bubble=1 each cycle. Combine with lu → D_bubble=0, D_stall=1.
- Mispredict: E_icode=7, e_Cnd=0 → D_bubble=1, E_bubble=1, F_stall=0. With e_Cnd=1 → all 0.
- Exception/halt:
  - m_stat=3 → M_bubble=1 only.
  - Next cycle W_stat=3 → W_stall=1; next edge halted=1, final_stat=3.
  - go pulse afterwards → stays HALTED.
  - rst → IDLE, final_stat=1.
- Perf (PIPE_CTRL_PERF_EN, CNT_W=4): 20 RUN cycles → cyc_cnt=15 (saturated). ret_cnt counts only non-NOP W entries with W_stat=1. Counters hold in HALTED and clear on rst.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants, pipeline-control state encoding and the exception-status helper.
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;
  function automatic logic is_exc(input logic [2:0] s);
    return s == S_HLT || s == S_ADR || s == S_INS;
  endfunction
endpackage

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: combinational load/use (lu), ret (rt) and mispredict (mp) hazard terms.
// Inputs: D/E/M stage icodes, decode sources, E_dstM, e_Cnd. Outputs: lu, rt, mp.
module pipe_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  output logic       lu,
  output logic       rt,
  output logic       mp
);
  assign lu = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && E_dstM != RNONE &&
              (E_dstM == d_srcA || E_dstM == d_srcB);
  assign rt = D_icode == I_RET || E_icode == I_RET || M_icode == I_RET;
  assign mp = E_icode == I_JXX && !e_Cnd;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86-64 pipeline control - stall/bubble generation, IDLE/RUN/HALTED sequencing.
// Inputs: clk, rst (sync, active high), go, stage icodes/regs/status. Outputs: F/D/W stalls,
// D/E/M bubbles, running, halted, final_stat. With PIPE_CTRL_PERF_EN defined, adds saturating
// CNT_W-bit counters cyc_cnt, ret_cnt, stall_cnt, bub_cnt that count only in RUN.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             running,
  output logic             halted,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bub_cnt,
`endif
  output logic [2:0]       final_stat
);
  state_t state, state_nx;
  logic lu, rt, mp, run, w_exc;
  pipe_hazard_detect u_hz (
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB), .E_icode(E_icode),
    .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .lu(lu), .rt(rt), .mp(mp)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      final_stat <= S_AOK;
    end else begin
      state <= state_nx;
      if (run && w_exc) final_stat <= W_stat;
    end
  end
  // Outside RUN every register is frozen: stalls hold F/D/W, E and M get NOPs.
  always_comb begin
    run      = state == RUN;
    w_exc    = is_exc(W_stat);
    state_nx = state == IDLE && go ? RUN : run && w_exc ? HALTED : state;
    running  = run;
    halted   = state == HALTED;
    F_stall  = run ? lu | rt : 1'b1;
    D_stall  = run ? lu : 1'b1;
    D_bubble = run ? mp | (rt & ~lu) : 1'b0;
    E_bubble = run ? mp | lu : 1'b1;
    M_bubble = run ? is_exc(m_stat) | w_exc : 1'b1;
    W_stall  = run ? w_exc : 1'b1;
  end
`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt   <= '0;
      ret_cnt   <= '0;
      stall_cnt <= '0;
      bub_cnt   <= '0;
    end else if (run) begin
      if (~&cyc_cnt) cyc_cnt <= cyc_cnt + ONE;
      if (~&ret_cnt && W_stat == S_AOK && W_icode != I_NOP) ret_cnt <= ret_cnt + ONE;
      if (~&stall_cnt && F_stall) stall_cnt <= stall_cnt + ONE;
      if (~&bub_cnt && (D_bubble || E_bubble)) bub_cnt <= bub_cnt + ONE;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = ^{W_icode, {CNT_W{1'b0}}};
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a rule-level reference model.
module tb_pipe_ctrl;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst, go, e_Cnd;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic [2:0] m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, running, halted;
  logic [2:0] final_stat;
`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] cyc_cnt, ret_cnt, stall_cnt, bub_cnt;
`endif
  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .go(go), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
    .W_icode(W_icode), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .running(running), .halted(halted),
`ifdef PIPE_CTRL_PERF_EN
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt), .bub_cnt(bub_cnt),
`endif
    .final_stat(final_stat)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  bit m_run = 0, m_halt = 0;
  int m_fstat = 1, m_cyc = 0, m_ret = 0, m_stall = 0, m_bub = 0;
  wire [10:0] act_all = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
                         running, halted, final_stat};
  function automatic bit exc(input int s);
    return s >= 2 && s <= 4;
  endfunction
  // Returns {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} from the hazard rules.
  function automatic logic [5:0] exp_ctl();
    bit lu, rt, mp;
    lu = (E_icode == 5 || E_icode == 11) && E_dstM != 15 && (E_dstM == d_srcA || E_dstM == d_srcB);
    rt = D_icode == 9 || E_icode == 9 || M_icode == 9;
    mp = E_icode == 7 && !e_Cnd;
    if (!m_run) return 6'b110111;
    return {lu || rt, lu, mp || (rt && !lu), mp || lu, exc(m_stat) || exc(W_stat), exc(W_stat)};
  endfunction
  function automatic logic [10:0] exp_all();
    return {exp_ctl(), m_run, m_halt, 3'(m_fstat)};
  endfunction
  function automatic int sat(input int v, input bit en);
    return (en && v < CMAX) ? v + 1 : v;
  endfunction
  task automatic step();
    logic [5:0] c;
    c = exp_ctl();
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_halt = 0; m_fstat = 1;
      m_cyc = 0; m_ret = 0; m_stall = 0; m_bub = 0;
    end else if (m_run) begin
      m_cyc   = sat(m_cyc, 1);
      m_ret   = sat(m_ret, W_stat == 1 && W_icode != 1);
      m_stall = sat(m_stall, c[5]);
      m_bub   = sat(m_bub, c[3] || c[2]);
      if (exc(W_stat)) begin m_run = 0; m_halt = 1; m_fstat = W_stat; end
    end else if (!m_halt && go) m_run = 1;
    @(negedge clk);
  endtask
  task automatic set_nop();
    rst = 0; go = 0; e_Cnd = 1;
    D_icode = 1; E_icode = 1; M_icode = 1; W_icode = 1;
    d_srcA = 15; d_srcB = 15; E_dstM = 15; m_stat = 1; W_stat = 1;
  endtask
  task automatic test_reset();
    set_nop(); rst = 1; step(); rst = 0;
    for (int i = 0; i < 5; i++) begin
      #1 tests++;
      if (act_all !== exp_all()) begin fails++; $display("FAIL reset_idle got=%b want=%b", act_all, exp_all()); end
      step();
    end
    go = 1; step(); go = 0;
    #1 tests++;
    if (act_all !== exp_all()) begin fails++; $display("FAIL start_run got=%b want=%b", act_all, exp_all()); end
  endtask
  task automatic test_load_use();
    E_icode = 5; E_dstM = 3; d_srcA = 3;
    #1 tests++;
    if (act_all !== exp_all()) begin fails++; $display("FAIL load_use got=%b want=%b", act_all, exp_all()); end
    step(); E_dstM = 15; d_srcA = 15;
    #1 tests++;
    if (act_all !== exp_all()) begin fails++; $display("FAIL load_use_rnone got=%b want=%b", act_all, exp_all()); end
    step(); set_nop();
  endtask
  task automatic test_ret();
    D_icode = 9;
    for (int i = 0; i < 3; i++) begin
      #1 tests++;
      if (act_all !== exp_all()) begin fails++; $display("FAIL ret_%0d got=%b want=%b", i, act_all, exp_all()); end
      step();
    end
    E_icode = 11; E_dstM = 4; d_srcB = 4;
    #1 tests++;
    if (act_all !== exp_all()) begin fails++; $display("FAIL ret_lu got=%b want=%b", act_all, exp_all()); end
    step(); set_nop();
  endtask
  task automatic test_mispredict();
    E_icode = 7; e_Cnd = 0;
    #1 tests++;
    if (act_all !== exp_all()) begin fails++; $display("FAIL mispredict got=%b want=%b", act_all, exp_all()); end
    step(); e_Cnd = 1;
    #1 tests++;
    if (act_all !== exp_all()) begin fails++; $display("FAIL jxx_taken got=%b want=%b", act_all, exp_all()); end
    step(); set_nop();
  endtask
  task automatic test_halt();
    m_stat = 3;
    #1 tests++;
    if (act_all !== exp_all()) begin fails++; $display("FAIL m_exc got=%b want=%b", act_all, exp_all()); end
    step(); m_stat = 1; W_stat = 3;
    #1 tests++;
    if (act_all !== exp_all()) begin fails++; $display("FAIL w_exc got=%b want=%b", act_all, exp_all()); end
    step(); W_stat = 1;
    #1 tests++;
    if (act_all !== exp_all()) begin fails++; $display("FAIL halted got=%b want=%b", act_all, exp_all()); end
    go = 1; step(); go = 0;
    #1 tests++;
    if (act_all !== exp_all()) begin fails++; $display("FAIL halt_sticky got=%b want=%b", act_all, exp_all()); end
    rst = 1; go = 1; step(); rst = 0; go = 0;
    #1 tests++;
    if (act_all !== exp_all()) begin fails++; $display("FAIL halt_reset got=%b want=%b", act_all, exp_all()); end
  endtask
  function automatic logic [3:0] ric();
    int k;
    k = $urandom_range(0, 6);
    return k == 0 ? 4'd1 : k == 1 ? 4'd5 : k == 2 ? 4'd7 : k == 3 ? 4'd9 : k == 4 ? 4'd11 :
           k == 5 ? 4'd0 : 4'($urandom);
  endfunction
  function automatic logic [3:0] rreg();
    return $urandom_range(0, 4) == 0 ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 60) == 0; go = $urandom_range(0, 5) == 0;
      D_icode = ric(); E_icode = ric(); M_icode = ric(); W_icode = ric();
      d_srcA = rreg(); d_srcB = rreg(); E_dstM = rreg(); e_Cnd = 1'($urandom);
      m_stat = $urandom_range(0, 5) == 0 ? 3'($urandom) : 3'd1;
      W_stat = $urandom_range(0, 25) == 0 ? 3'($urandom) : 3'(($urandom_range(0, 3) == 0) ? 0 : 1);
      if (m_halt && $urandom_range(0, 3) == 0) rst = 1;
      #1 tests++;
      if (act_all !== exp_all()) begin fails++; $display("FAIL random_%0d got=%b want=%b", i, act_all, exp_all()); end
`ifdef PIPE_CTRL_PERF_EN
      tests++;
      if ({cyc_cnt, ret_cnt, stall_cnt, bub_cnt} !== {4'(m_cyc), 4'(m_ret), 4'(m_stall), 4'(m_bub)}) begin
        fails++;
        $display("FAIL random_cnt_%0d got=%h/%h/%h/%h want=%0d/%0d/%0d/%0d", i, cyc_cnt, ret_cnt, stall_cnt, bub_cnt, m_cyc, m_ret, m_stall, m_bub);
      end
`endif
      step();
    end
    set_nop();
  endtask
`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    set_nop(); rst = 1; step(); rst = 0; go = 1; step(); go = 0;
    for (int i = 0; i < 20; i++) begin
      W_icode = $urandom_range(0, 1) ? 4'd1 : 4'd6;
      W_stat = $urandom_range(0, 3) == 0 ? 3'd0 : 3'd1;
      D_icode = $urandom_range(0, 3) == 0 ? 4'd9 : 4'd1;
      step();
    end
    set_nop();
    #1 tests++;
    if ({cyc_cnt, ret_cnt, stall_cnt, bub_cnt} !== {4'(m_cyc), 4'(m_ret), 4'(m_stall), 4'(m_bub)} || cyc_cnt !== 4'hF) begin
      fails++; $display("FAIL perf_sat got=%h/%h/%h/%h want=%0d/%0d/%0d/%0d", cyc_cnt, ret_cnt, stall_cnt, bub_cnt, m_cyc, m_ret, m_stall, m_bub);
    end
    W_stat = 2; step(); W_stat = 1; W_icode = 6; step(); step();
    #1 tests++;
    if ({cyc_cnt, ret_cnt, stall_cnt, bub_cnt} !== {4'(m_cyc), 4'(m_ret), 4'(m_stall), 4'(m_bub)}) begin
      fails++; $display("FAIL perf_hold got=%h/%h/%h/%h want=%0d/%0d/%0d/%0d", cyc_cnt, ret_cnt, stall_cnt, bub_cnt, m_cyc, m_ret, m_stall, m_bub);
    end
    rst = 1; step(); rst = 0;
    #1 tests++;
    if ({cyc_cnt, ret_cnt, stall_cnt, bub_cnt} !== 16'h0) begin
      fails++; $display("FAIL perf_clear got=%h/%h/%h/%h want=0/0/0/0", cyc_cnt, ret_cnt, stall_cnt, bub_cnt);
    end
    set_nop();
  endtask
`endif
  initial begin
    set_nop();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_ret();
    test_mispredict();
    test_halt();
    test_random();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
